bp_cfg_loader: RTL and testbench

BP_CFG_LOADER -- requirements
Module: bp_cfg_loader

---
 rtl/bp_common_cfg_link_pkg.sv | 55 +++++
 rtl/bp_cfg_loader.sv | 178 +++++++++++++++++
 tb/tb_bp_cfg_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bp_common_cfg_link_pkg.sv
// -----------------------------------------------------------------------------
// bp_common_cfg_link_pkg
//   Shared definitions for the configuration loader. It holds the
//   configuration-register map, the table of processor configurations and the
//   loader state encoding.
//
//   Contents
//     bp_params_e            : processor configuration selector
//     bp_proc_param_s        : per-configuration sizing record
//     all_cfgs_gp            : sizing record for each bp_params_e value
//     cfg_reg_*_gp           : configuration register addresses
//     cfg_ucode_base_gp      : base address of the CCE microcode window
//     bp_cfg_loader_state_e  : loader FSM states
// -----------------------------------------------------------------------------
package bp_common_cfg_link_pkg;

   typedef enum logic [1:0] {
      e_bp_inv_cfg         = 2'd0,
      e_bp_single_core_cfg = 2'd1,
      e_bp_dual_core_cfg   = 2'd2
   } bp_params_e;

   typedef struct packed {
      int num_core;
      int cfg_core_width;
      int cfg_addr_width;
      int cfg_data_width;
      int num_cce_instr_ram_els;
   } bp_proc_param_s;

   // Indexed by bp_params_e. The default selector e_bp_inv_cfg maps to a
   // minimal single-core system so an unparameterised instance still builds.
   localparam bp_proc_param_s all_cfgs_gp [3] = '{
      '{1, 1, 16, 32, 256},   // e_bp_inv_cfg
      '{1, 1, 16, 32, 256},   // e_bp_single_core_cfg
      '{2, 1, 16, 32, 256}    // e_bp_dual_core_cfg
   };

   localparam logic [15:0] cfg_reg_freeze_gp   = 16'h0001;
   localparam logic [15:0] cfg_reg_core_id_gp  = 16'h0002;
   localparam logic [15:0] cfg_reg_cce_mode_gp = 16'h0003;
   localparam logic [15:0] cfg_ucode_base_gp   = 16'h8000;

   typedef enum logic [2:0] {
      e_reset    = 3'd0,
      e_freeze   = 3'd1,
      e_core_id  = 3'd2,
      e_ucode_rd = 3'd3,
      e_ucode_wr = 3'd4,
      e_cce_mode = 3'd5,
      e_unfreeze = 3'd6,
      e_done     = 3'd7
   } bp_cfg_loader_state_e;

endpackage

// File: rtl/bp_cfg_loader.sv
// -----------------------------------------------------------------------------
// bp_cfg_loader
//   Walks every core through a fixed configuration sequence after reset:
//   freeze, core id, (optional) CCE microcode load, CCE mode, unfreeze.
//   Writes use a valid/ready handshake; the request is held stable until
//   it is accepted.
//
//   Build option
//     BP_CFG_LOADER_UCODE_EN : when defined, the microcode is streamed from an
//                              external synchronous ROM into the cfg window at
//                              cfg_ucode_base_gp. When undefined, each core
//                              gets exactly four writes and the ROM port is
//                              inert.
//
//   Ports
//     clk_i        in   clock
//     reset_i      in   synchronous active-high reset
//     cfg_v_o      out  config write valid
//     cfg_core_o   out  target core of the write
//     cfg_addr_o   out  config register address
//     cfg_data_o   out  config write data
//     cfg_ready_i  in   consumer accepts the write this cycle
//     ucode_addr_o out  microcode ROM read address
//     ucode_data_i in   microcode ROM data, one cycle after the address
//     done_o       out  every core configured (sticky until reset)
// -----------------------------------------------------------------------------
module bp_cfg_loader
   import bp_common_cfg_link_pkg::*;
#(
   parameter  bp_params_e     cfg_p                 = e_bp_inv_cfg,
   localparam bp_proc_param_s proc_param_lp         = all_cfgs_gp[cfg_p],
   localparam int             num_core              = proc_param_lp.num_core,
   localparam int             cfg_core_width        = proc_param_lp.cfg_core_width,
   localparam int             cfg_addr_width        = proc_param_lp.cfg_addr_width,
   localparam int             cfg_data_width        = proc_param_lp.cfg_data_width,
   localparam int             num_cce_instr_ram_els = proc_param_lp.num_cce_instr_ram_els,
   localparam int             ucode_addr_width      = (num_cce_instr_ram_els > 1)
                                                      ? $clog2(num_cce_instr_ram_els) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   output logic                        cfg_v_o,
   output logic [cfg_core_width-1:0]   cfg_core_o,
   output logic [cfg_addr_width-1:0]   cfg_addr_o,
   output logic [cfg_data_width-1:0]   cfg_data_o,
   input  logic                        cfg_ready_i,
   output logic [ucode_addr_width-1:0] ucode_addr_o,
   input  logic [cfg_data_width-1:0]   ucode_data_i,
   output logic                        done_o
);

   bp_cfg_loader_state_e        state_r, state_n;
   logic [cfg_core_width-1:0]   core_r, core_n;

`ifdef BP_CFG_LOADER_UCODE_EN
   logic [ucode_addr_width-1:0] idx_r, idx_n;
   logic                        wr_first_r;
   logic [cfg_data_width-1:0]   ucode_data_r;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, regardless of process ordering.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= e_reset;
         core_r     <= '0;
`ifdef BP_CFG_LOADER_UCODE_EN
         idx_r      <= '0;
         wr_first_r <= 1'b0;
`endif
      end else begin
         state_r    <= state_n;
         core_r     <= core_n;
`ifdef BP_CFG_LOADER_UCODE_EN
         idx_r      <= idx_n;
         // High only in the first e_ucode_wr cycle, when the ROM output is
         // live for the address presented during e_ucode_rd.
         wr_first_r <= (state_r == e_ucode_rd);
`endif
      end
   end

`ifdef BP_CFG_LOADER_UCODE_EN
   // NOTE: pure datapath holding register, deliberately left out of reset;
   // it is only observed after wr_first_r has loaded it.
   always_ff @(posedge clk_i) begin
      if (wr_first_r) ucode_data_r <= ucode_data_i;
   end

   assign ucode_addr_o = idx_r;
`else
   logic unused_ucode;
   assign unused_ucode = ^ucode_data_i;
   assign ucode_addr_o = '0;
`endif

   assign cfg_core_o = core_r;
   assign done_o     = (state_r == e_done);

   // NOTE: every output of this block is given a default first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_n    = state_r;
      core_n     = core_r;
      cfg_v_o    = 1'b0;
      cfg_addr_o = '0;
      cfg_data_o = '0;
`ifdef BP_CFG_LOADER_UCODE_EN
      idx_n      = idx_r;
`endif
      case (state_r)
         e_reset: state_n = e_freeze;

         e_freeze: begin
            cfg_v_o    = 1'b1;
            cfg_addr_o = cfg_addr_width'(cfg_reg_freeze_gp);
            cfg_data_o = cfg_data_width'(1);
            if (cfg_ready_i) state_n = e_core_id;
         end

         e_core_id: begin
            cfg_v_o    = 1'b1;
            cfg_addr_o = cfg_addr_width'(cfg_reg_core_id_gp);
            cfg_data_o = cfg_data_width'(core_r);
`ifdef BP_CFG_LOADER_UCODE_EN
            if (cfg_ready_i) state_n = e_ucode_rd;
`else
            if (cfg_ready_i) state_n = e_cce_mode;
`endif
         end

`ifdef BP_CFG_LOADER_UCODE_EN
         e_ucode_rd: state_n = e_ucode_wr;

         e_ucode_wr: begin
            cfg_v_o    = 1'b1;
            cfg_addr_o = cfg_addr_width'(cfg_ucode_base_gp + 16'(idx_r));
            cfg_data_o = wr_first_r ? ucode_data_i : ucode_data_r;
            if (cfg_ready_i) begin
               if (idx_r == ucode_addr_width'(num_cce_instr_ram_els - 1)) begin
                  idx_n   = '0;
                  state_n = e_cce_mode;
               end else begin
                  idx_n   = idx_r + 1'b1;
                  state_n = e_ucode_rd;
               end
            end
         end
`endif

         e_cce_mode: begin
            cfg_v_o    = 1'b1;
            cfg_addr_o = cfg_addr_width'(cfg_reg_cce_mode_gp);
            cfg_data_o = cfg_data_width'(1);
            if (cfg_ready_i) state_n = e_unfreeze;
         end

         e_unfreeze: begin
            cfg_v_o    = 1'b1;
            cfg_addr_o = cfg_addr_width'(cfg_reg_freeze_gp);
            cfg_data_o = '0;
            if (cfg_ready_i) begin
               if (core_r == cfg_core_width'(num_core - 1)) begin
                  state_n = e_done;
               end else begin
                  core_n  = core_r + 1'b1;
                  state_n = e_freeze;
               end
            end
         end

         e_done: state_n = e_done;

         default: state_n = e_reset;
      endcase
   end

endmodule

// File: tb/tb_bp_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_bp_cfg_loader
//   Directed bench for bp_cfg_loader in the dual-core configuration. Follows
//   BP_CFG_LOADER_UCODE_EN so the expected write list matches the build.
// -----------------------------------------------------------------------------
module tb_bp_cfg_loader;
   import bp_common_cfg_link_pkg::*;

   localparam int n_core  = 2;
   localparam int n_ucode = 256;
`ifdef BP_CFG_LOADER_UCODE_EN
   localparam int cyc_per_core = 4 + 2 * n_ucode;
`else
   localparam int cyc_per_core = 4;
`endif
   localparam int exp_cycles = 1 + n_core * cyc_per_core;

   typedef struct packed {
      logic [0:0]  core;
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        cfg_v_o;
   logic [0:0]  cfg_core_o;
   logic [15:0] cfg_addr_o;
   logic [31:0] cfg_data_o;
   logic        cfg_ready_i;
   logic [7:0]  ucode_addr_o;
   logic [31:0] ucode_data_i;
   logic        done_o;

   int n_tests = 0;
   int n_fail  = 0;

   bp_cfg_loader #(.cfg_p(e_bp_dual_core_cfg)) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .cfg_v_o     (cfg_v_o),
      .cfg_core_o  (cfg_core_o),
      .cfg_addr_o  (cfg_addr_o),
      .cfg_data_o  (cfg_data_o),
      .cfg_ready_i (cfg_ready_i),
      .ucode_addr_o(ucode_addr_o),
      .ucode_data_i(ucode_data_i),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data = address ^ 32'hA5A5_0000, one cycle after addr.
   always @(posedge clk) ucode_data_i <= {24'h0, ucode_addr_o} ^ 32'hA5A5_0000;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected write sequence, built from the register map by hand.
   wr_t exp_q[$];

   // Write monitor: checks every accepted write against exp_q and holds
   // the request stable while it is stalled.
   logic mon_en = 1'b0;
   int   wr_idx = 0;
   logic stall_prev = 1'b0;
   wr_t  prev_wr;

   always @(negedge clk) begin
      if (!mon_en) begin
         wr_idx     <= 0;
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid", 64'(cfg_v_o), 64'd1);
            check("stall_hold", 64'({cfg_core_o, cfg_addr_o, cfg_data_o}), 64'(prev_wr));
         end
         if (cfg_v_o && cfg_ready_i) begin
            if (wr_idx < exp_q.size())
               check($sformatf("wr_%0d", wr_idx),
                     64'({cfg_core_o, cfg_addr_o, cfg_data_o}), 64'(exp_q[wr_idx]));
            wr_idx <= wr_idx + 1;
         end
         stall_prev <= cfg_v_o && !cfg_ready_i;
         prev_wr    <= {cfg_core_o, cfg_addr_o, cfg_data_o};
      end
   end

   // Runs until done_o, driving ready each cycle; returns edges since release.
   task automatic run_to_done(input bit rand_ready, output int cycles);
      cycles = 0;
      for (int k = 1; k <= 20000; k++) begin
         @(posedge clk); #1;
         cycles = k;
         if (done_o) break;
         cfg_ready_i = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
      check("done_reached", 64'(done_o), 64'd1);
   endtask

   task automatic apply_reset();
      mon_en      = 1'b0;
      reset_i     = 1'b1;
      cfg_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b0;
      mon_en  = 1'b1;
   endtask

   int cycles;
   int bad;
   logic found;

   initial begin
      for (int c = 0; c < n_core; c++) begin
         exp_q.push_back('{core: 1'(c), addr: 16'h0001, data: 32'd1});
         exp_q.push_back('{core: 1'(c), addr: 16'h0002, data: 32'(c)});
`ifdef BP_CFG_LOADER_UCODE_EN
         for (int i = 0; i < n_ucode; i++)
            exp_q.push_back('{core: 1'(c), addr: 16'h8000 + 16'(i),
                              data: 32'(i) ^ 32'hA5A5_0000});
`endif
         exp_q.push_back('{core: 1'(c), addr: 16'h0003, data: 32'd1});
         exp_q.push_back('{core: 1'(c), addr: 16'h0001, data: 32'd0});
      end

      // Reset values.
      reset_i     = 1'b1;
      cfg_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_v",     64'(cfg_v_o),      64'd0);
      check("rst_done",  64'(done_o),       64'd0);
      check("rst_core",  64'(cfg_core_o),   64'd0);
      check("rst_addr",  64'(cfg_addr_o),   64'd0);
      check("rst_data",  64'(cfg_data_o),   64'd0);
      check("rst_uaddr", 64'(ucode_addr_o), 64'd0);

      // Pass 1: ready tied high; exact write list and latency.
      apply_reset();
      cfg_ready_i = 1'b1;
      run_to_done(1'b0, cycles);
      check("p1_cycles", 64'(cycles), 64'(exp_cycles));
      check("p1_writes", 64'(wr_idx), 64'(exp_q.size()));
`ifndef BP_CFG_LOADER_UCODE_EN
      check("p1_uaddr_tied", 64'(ucode_addr_o), 64'd0);
`endif

      // done_o is sticky and cfg_ready_i is ignored afterwards.
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         cfg_ready_i = ~cfg_ready_i;
         if (cfg_v_o !== 1'b0 || done_o !== 1'b1) bad++;
      end
      check("post_done_quiet", 64'(bad), 64'd0);

      // Pass 2: 30% random ready; same sequence, stalls held stable.
      apply_reset();
      run_to_done(1'b1, cycles);
      check("p2_writes", 64'(wr_idx), 64'(exp_q.size()));

      // Pass 3: reset during a stalled write, then restart from core 0.
      apply_reset();
      cfg_ready_i = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 5000 && !found; k++) begin
         @(posedge clk); #1;
`ifdef BP_CFG_LOADER_UCODE_EN
         if (cfg_v_o && cfg_core_o == 1'b0 && cfg_addr_o == 16'h8064) found = 1'b1;
`else
         if (cfg_v_o && cfg_core_o == 1'b1 && cfg_addr_o == 16'h0003) found = 1'b1;
`endif
         if (found) cfg_ready_i = 1'b0;
      end
      check("p3_target_seen", 64'(found), 64'd1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("p3_stalled_v", 64'(cfg_v_o), 64'd1);
      mon_en  = 1'b0;
      reset_i = 1'b1;
      @(posedge clk); #1;
      check("p3_abort_v",    64'(cfg_v_o),    64'd0);
      check("p3_abort_core", 64'(cfg_core_o), 64'd0);
      check("p3_abort_done", 64'(done_o),     64'd0);
      reset_i     = 1'b0;
      mon_en      = 1'b1;
      cfg_ready_i = 1'b1;
      run_to_done(1'b0, cycles);
      check("p3_cycles", 64'(cycles), 64'(exp_cycles));
      check("p3_writes", 64'(wr_idx), 64'(exp_q.size()));

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
